// File: rtl/mux_pkg.sv
// Shared definitions for the mux_arb_n router output stage: flit type codes,
// FSM state encoding and the popcount helper used by the optional toggle counter.
package mux_pkg;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  // The type field occupies the top TYPE_W bits of a flit: [FLITW-1 -: TYPE_W].
  localparam int TYPE_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int POPCNT_MAXW = 256;

  function automatic logic [31:0] popcount(input logic [POPCNT_MAXW-1:0] v);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < POPCNT_MAXW; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mux_arb_n_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// i_ptr, searching upward and wrapping from NPORT-1 back to 0.
module rr_arb_n
  import mux_pkg::*;
#(
  parameter int NPORT = 5,
  parameter int RRW   = 3
) (
  input  logic [NPORT-1:0] i_req,
  input  logic [RRW-1:0]   i_ptr,
  output logic [NPORT-1:0] o_grant,
  output logic [RRW-1:0]   o_idx,
  output logic             o_valid
);

  // First hit wins; o_valid doubles as the "already granted" flag.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      int p;
      p = (int'(i_ptr) + k) % NPORT;
      if (!o_valid && i_req[p]) begin
        o_grant[p] = 1'b1;
        o_idx      = RRW'(p);
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N:1 router output mux with packet-aware round-robin arbitration and a
// registered valid/ready output. Optional toggle counter: MUX_TOGGLE_CNT_EN.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter int NPORT = 5,
  parameter int FLITW = 66,
  parameter int VCHW  = 2,
  parameter int RRW   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT*FLITW-1:0] idata,
  input  logic [NPORT-1:0]       ivalid,
  input  logic [NPORT*VCHW-1:0]  ivch,
  output logic [NPORT-1:0]       iready,
  output logic [FLITW-1:0]       odata,
  output logic                   ovalid,
  output logic [VCHW-1:0]        ovch,
  input  logic                   oready,
  output logic                   oerr
`ifdef MUX_TOGGLE_CNT_EN
  ,
  output logic [31:0]            toggle_cnt
`endif
);

  state_t           r_state;
  logic [RRW-1:0]   r_owner;
  logic [RRW-1:0]   r_rrPtr;
  logic [FLITW-1:0] r_odata;
  logic [VCHW-1:0]  r_ovch;
  logic             r_ovalid;
  logic             r_oerr;

  logic             w_canLoad;
  logic [NPORT-1:0] w_grant;
  logic [RRW-1:0]   w_arbIdx;
  logic             w_arbValid;
  logic [RRW-1:0]   w_selIdx;
  logic [FLITW-1:0] w_selData;
  logic [VCHW-1:0]  w_selVch;
  logic [1:0]       w_selType;
  logic [NPORT-1:0] w_iready;
  logic             w_take;
  logic             w_load;

  rr_arb_n #(
    .NPORT(NPORT),
    .RRW  (RRW)
  ) u_arb (
    .i_req  (ivalid),
    .i_ptr  (r_rrPtr),
    .o_grant(w_grant),
    .o_idx  (w_arbIdx),
    .o_valid(w_arbValid)
  );

  assign w_canLoad = ~r_ovalid | oready;
  assign w_selIdx  = (r_state == IDLE) ? w_arbIdx : r_owner;
  assign w_selData = idata[w_selIdx*FLITW +: FLITW];
  assign w_selVch  = ivch[w_selIdx*VCHW +: VCHW];
  assign w_selType = w_selData[FLITW-1 -: TYPE_W];

  // Take = flit consumed from an input; load = flit written into the output register.
  always_comb begin
    w_iready = '0;
    w_take   = 1'b0;
    w_load   = 1'b0;
    if (!rst && w_canLoad) begin
      if (r_state == IDLE) begin
        if (w_arbValid) begin
          w_iready = w_grant;
          w_take   = 1'b1;
          w_load   = (w_selType == TYPE_HEAD);
        end
      end else if (ivalid[r_owner]) begin
        w_iready[r_owner] = 1'b1;
        w_take            = 1'b1;
        w_load            = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_odata  <= '0;
      r_ovch   <= '0;
      r_ovalid <= 1'b0;
    end else if (w_load) begin
      r_odata  <= w_selData;
      r_ovch   <= w_selVch;
      r_ovalid <= 1'b1;
    end else if (oready) begin
      r_ovalid <= 1'b0;
    end
  end

  // Packet lock: the round-robin pointer only advances when a packet completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_rrPtr <= '0;
      r_oerr  <= 1'b0;
    end else if (w_take) begin
      case (r_state)
        IDLE: begin
          if (w_selType == TYPE_HEAD) begin
            r_state <= LOCKED;
            r_owner <= w_arbIdx;
          end else begin
            r_oerr <= 1'b1;
          end
        end
        LOCKED: begin
          if (w_selType == TYPE_TAIL) begin
            r_state <= IDLE;
            r_rrPtr <= (r_owner == RRW'(NPORT-1)) ? '0 : r_owner + 1'b1;
          end else if (w_selType != TYPE_DATA) begin
            r_oerr <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MUX_TOGGLE_CNT_EN
  logic [31:0] r_toggleCnt;
  logic [32:0] w_toggleSum;

  assign w_toggleSum = {1'b0, r_toggleCnt} +
                       {1'b0, popcount(POPCNT_MAXW'(w_selData ^ r_odata))};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_toggleCnt <= '0;
    end else if (w_load) begin
      r_toggleCnt <= w_toggleSum[32] ? '1 : w_toggleSum[31:0];
    end
  end

  assign toggle_cnt = r_toggleCnt;
`endif

  assign iready = w_iready;
  assign odata  = r_odata;
  assign ovalid = r_ovalid;
  assign ovch   = r_ovch;
  assign oerr   = r_oerr;

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n: a packet-level reference model predicts grants
// and output flits; a separate monitor compares the registered output stage.
module tb_mux_arb_n;

  localparam int NPORT = 5;
  localparam int FLITW = 66;
  localparam int VCHW  = 2;
  localparam int RRW   = 3;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  typedef struct packed {
    logic [FLITW-1:0] data;
    logic [VCHW-1:0]  vch;
  } flit_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NPORT*FLITW-1:0] idata;
  logic [NPORT-1:0]       ivalid;
  logic [NPORT*VCHW-1:0]  ivch;
  logic [NPORT-1:0]       iready;
  logic [FLITW-1:0]       odata;
  logic                   ovalid;
  logic [VCHW-1:0]        ovch;
  logic                   oready;
  logic                   oerr;
`ifdef MUX_TOGGLE_CNT_EN
  logic [31:0]            toggleCnt;
`endif

  mux_arb_n #(
    .NPORT(NPORT),
    .FLITW(FLITW),
    .VCHW (VCHW),
    .RRW  (RRW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .idata (idata),
    .ivalid(ivalid),
    .ivch  (ivch),
    .iready(iready),
    .odata (odata),
    .ovalid(ovalid),
    .ovch  (ovch),
    .oready(oready),
    .oerr  (oerr)
`ifdef MUX_TOGGLE_CNT_EN
    ,
    .toggle_cnt(toggleCnt)
`endif
  );

  always #5 clk = ~clk;

  flit_t src[NPORT][$];
  flit_t sb[$];

  int checks   = 0;
  int errors   = 0;
  int outCount = 0;
  int accCount = 0;
  int validPct = 100;
  int readyPct = 100;

  bit               mLocked    = 1'b0;
  int               mOwner     = 0;
  int               mPtr       = 0;
  bit               mErr       = 1'b0;
  logic [FLITW-1:0] mLastOdata = '0;
  longint           mToggle    = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic flit_t mkFlit(input logic [1:0] t, input logic [FLITW-3:0] pay,
                                   input logic [VCHW-1:0] vc);
    flit_t f;
    f.data = {t, pay};
    f.vch  = vc;
    return f;
  endfunction

  function automatic logic [FLITW-3:0] rndPay();
    return {$urandom, $urandom};
  endfunction

  task automatic addPacket(input int p, input int nData, input bit bad);
    logic [VCHW-1:0] vc;
    logic [1:0]      t;
    vc = VCHW'($urandom_range(3));
    src[p].push_back(mkFlit(T_HEAD, rndPay(), vc));
    for (int i = 0; i < nData; i++) begin
      t = T_DATA;
      if (bad && $urandom_range(1) == 0) t = ($urandom_range(1) == 0) ? T_NONE : T_HEAD;
      src[p].push_back(mkFlit(t, rndPay(), vc));
    end
    src[p].push_back(mkFlit(T_TAIL, rndPay(), vc));
  endtask

  function automatic bit busy();
    bit b;
    b = (sb.size() > 0);
    for (int p = 0; p < NPORT; p++) if (src[p].size() > 0) b = 1'b1;
    return b;
  endfunction

  // One cycle per iteration: drive at negedge, predict the grant from packet rules, commit at posedge.
  task automatic applyStimulus(input int nCycles);
    for (int c = 0; c < nCycles; c++) begin
      logic [NPORT-1:0] expRdy;
      int               acc;
      bit               doLoad;
      bit               errNext;
      flit_t            item;
      logic [1:0]       t;
      @(negedge clk);
      for (int p = 0; p < NPORT; p++) begin
        ivalid[p] = (src[p].size() > 0) && ($urandom_range(99) < validPct);
        idata[p*FLITW +: FLITW] = (src[p].size() > 0) ? src[p][0].data : '0;
        ivch[p*VCHW +: VCHW]    = (src[p].size() > 0) ? src[p][0].vch : '0;
      end
      oready = ($urandom_range(99) < readyPct);
      #1;
      expRdy  = '0;
      acc     = -1;
      doLoad  = 1'b0;
      errNext = 1'b0;
      item    = '0;
      if (!rst && (sb.size() == 0 || oready)) begin
        if (!mLocked) begin
          for (int k = 0; k < NPORT; k++) begin
            int q;
            q = (mPtr + k) % NPORT;
            if (acc < 0 && ivalid[q]) acc = q;
          end
        end else if (ivalid[mOwner]) begin
          acc = mOwner;
        end
      end
      if (acc >= 0) begin
        expRdy[acc] = 1'b1;
        item = src[acc].pop_front();
        t = item.data[FLITW-1 -: 2];
        accCount++;
        if (!mLocked) begin
          if (t == T_HEAD) begin
            doLoad  = 1'b1;
            mLocked = 1'b1;
            mOwner  = acc;
          end else begin
            errNext = 1'b1;
          end
        end else begin
          doLoad = 1'b1;
          if (t == T_TAIL) begin
            mLocked = 1'b0;
            mPtr    = (mOwner + 1) % NPORT;
          end else if (t != T_DATA) begin
            errNext = 1'b1;
          end
        end
      end
      checkOutput("iready", iready, expRdy);
      @(posedge clk);
      if (doLoad) begin
        sb.push_back(item);
        mToggle += $countones(item.data ^ mLastOdata);
        mLastOdata = item.data;
      end
      if (errNext) mErr = 1'b1;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst    = 1'b1;
    oready = 1'b0;
    ivalid = '1;
    for (int p = 0; p < NPORT; p++) idata[p*FLITW +: FLITW] = {T_HEAD, 64'h0};
    #1;
    sb.delete();
    for (int p = 0; p < NPORT; p++) src[p].delete();
    mLocked    = 1'b0;
    mOwner     = 0;
    mPtr       = 0;
    mErr       = 1'b0;
    mLastOdata = '0;
    mToggle    = 0;
    checkOutput("rst_ovalid", ovalid, 0);
    checkOutput("rst_odata", odata, 0);
    checkOutput("rst_ovch", ovch, 0);
    checkOutput("rst_oerr", oerr, 0);
    checkOutput("rst_iready", iready, 0);
`ifdef MUX_TOGGLE_CNT_EN
    checkOutput("rst_toggle", toggleCnt, 0);
`endif
    repeat (2) @(negedge clk);
    ivalid = '0;
    rst    = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int c;
    c = 0;
    validPct = 100;
    readyPct = 100;
    while (busy() && c < maxCycles) begin
      applyStimulus(1);
      #1;
      c++;
    end
    checkOutput("drain_timeout", busy(), 0);
  endtask

  // Monitor: the output register must always hold the oldest undelivered predicted flit.
  initial begin
    forever begin
      bit xfer;
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        checkOutput("ovalid", ovalid, 1);
        checkOutput("odata", odata, sb[0].data);
        checkOutput("ovch", ovch, sb[0].vch);
      end else begin
        checkOutput("ovalid_idle", ovalid, 0);
      end
      checkOutput("oerr", oerr, mErr);
`ifdef MUX_TOGGLE_CNT_EN
      checkOutput("toggle_cnt", toggleCnt, mToggle[31:0]);
`endif
      xfer = (sb.size() > 0) && oready;
      @(posedge clk);
      if (xfer && sb.size() > 0) begin
        void'(sb.pop_front());
        outCount++;
      end
    end
  end

  initial begin
    int c;
    ivalid = '0;
    idata  = '0;
    ivch   = '0;
    oready = 1'b0;

    doReset();

    // Single long packet on port 1 at full throughput.
    outCount = 0;
    addPacket(1, 20, 1'b0);
    waitDrain(200);
    checkOutput("t1_count", outCount, 22);
    checkOutput("t1_ovalid_after", ovalid, 0);

    // Pointer now at 2: port 2 must beat port 0 on a simultaneous HEAD.
    addPacket(0, 1, 1'b0);
    addPacket(2, 1, 1'b0);
    waitDrain(100);

    // Two simultaneous packets from pointer 0, with a 4-cycle stall mid-packet.
    doReset();
    outCount = 0;
    addPacket(0, 4, 1'b0);
    addPacket(3, 4, 1'b0);
    applyStimulus(5);
    readyPct = 0;
    applyStimulus(4);
    readyPct = 100;
    waitDrain(200);
    checkOutput("t2_count", outCount, 12);

    // Stray DATA flit while idle is discarded and flags an error.
    outCount = 0;
    src[2].push_back(mkFlit(T_DATA, rndPay(), 2'd1));
    waitDrain(20);
    applyStimulus(3);
    checkOutput("t4_oerr", oerr, 1);
    checkOutput("t4_count", outCount, 0);

    // Reset five flits into a packet, then a fresh packet on port 4.
    doReset();
    accCount = 0;
    addPacket(0, 10, 1'b0);
    c = 0;
    while (accCount < 5 && c < 50) begin
      applyStimulus(1);
      c++;
    end
    checkOutput("t5_progress", (accCount >= 5), 1);
    doReset();
    outCount = 0;
    addPacket(4, 3, 1'b0);
    waitDrain(100);
    checkOutput("t5_count", outCount, 5);

    // Randomized traffic with backpressure, gaps, stray flits and malformed packets.
    doReset();
    for (int r = 0; r < 40; r++) begin
      for (int p = 0; p < NPORT; p++) begin
        if ($urandom_range(3) == 0) addPacket(p, $urandom_range(5), ($urandom_range(7) == 0));
        if ($urandom_range(9) == 0)
          src[p].push_back(mkFlit(($urandom_range(1) == 0) ? T_DATA : T_TAIL, rndPay(), 2'd0));
      end
      validPct = $urandom_range(30, 100);
      readyPct = $urandom_range(30, 100);
      applyStimulus(20);
    end
    waitDrain(3000);

`ifdef MUX_TOGGLE_CNT_EN
    // HEAD(0), DATA(51 ones), DATA(0), TAIL(0): 1 + (2+51) + 51 + 1 toggles.
    doReset();
    src[0].push_back(mkFlit(T_HEAD, 64'h0, 2'd0));
    src[0].push_back(mkFlit(T_DATA, 64'h0007_FFFF_FFFF_FFFF, 2'd0));
    src[0].push_back(mkFlit(T_DATA, 64'h0, 2'd0));
    src[0].push_back(mkFlit(T_TAIL, 64'h0, 2'd0));
    waitDrain(50);
    checkOutput("toggle_total", toggleCnt, 106);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
